// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader and the MIPS top level.
package imem_loader_pkg;

   localparam int DEF_WIDTH   = 32;
   localparam int DEF_DEPTH   = 256;
   localparam int DEF_TIMEOUT = 1024;
   localparam int DEF_ADDR_W  = $clog2(DEF_DEPTH);
   localparam int LEN_W       = 9;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_RECV  = 3'd1,
      ST_WRITE = 3'd2,
      ST_DONE  = 3'd3,
      ST_ERROR = 3'd4
   } state_t;

   // Word counter must reach DEPTH itself and hold any len value.
   function automatic int cnt_width(input int depth);
      int w;
      w = $clog2(depth + 1);
      return (w > LEN_W) ? w : LEN_W;
   endfunction

endpackage

// File: rtl/imem_loader_word_packer.sv
// Shifts big-endian program bytes into a 32-bit word and counts bytes 0..3.
module word_packer (
   input  logic        clk,
   input  logic        rst,
   input  logic        clear,
   input  logic        shift_en,
   input  logic [7:0]  byte_in,
   output logic [31:0] word,
   output logic        last_byte
);

   logic [1:0] byte_cnt;

   assign last_byte = (byte_cnt == 2'd3);

   // First byte of a word ends up in bits 31:24 after four shifts.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (clear) begin
         word     <= '0;
         byte_cnt <= '0;
      end else if (shift_en) begin
         word     <= {word[23:0], byte_in};
         byte_cnt <= byte_cnt + 2'd1;
      end
   end

endmodule

// File: rtl/imem_loader.sv
// Streams program bytes into instruction memory while holding the CPU in reset.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int WIDTH   = DEF_WIDTH,
   parameter int DEPTH   = DEF_DEPTH,
   parameter int TIMEOUT = DEF_TIMEOUT
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [LEN_W-1:0]         len,
   input  logic                     byte_valid,
   input  logic [7:0]               byte_data,
   output logic                     byte_ready,
   output logic                     imem_we,
   output logic [$clog2(DEPTH)-1:0] imem_addr,
   output logic [WIDTH-1:0]         imem_wdata,
   output logic                     cpu_hold,
   output logic                     busy,
   output logic                     done,
   output logic                     err
);

   localparam int ADDR_W = $clog2(DEPTH);
   localparam int CNT_W  = cnt_width(DEPTH);
   localparam int TO_W   = $clog2(TIMEOUT + 1);

   state_t            state;
   state_t            state_next;
   logic [CNT_W-1:0]  word_cnt;
   logic [CNT_W-1:0]  word_inc;
   logic [CNT_W-1:0]  eff_len;
   logic [CNT_W-1:0]  len_eff;
   logic [TO_W-1:0]   to_cnt;
   logic [ADDR_W-1:0] addr_hold;
   logic [WIDTH-1:0]  wdata_hold;
   logic [31:0]       word;
   logic              last_byte;
   logic              byte_fire;
   logic              start_ok;

   assign byte_fire = (state == ST_RECV) && byte_valid;
   assign start_ok  = start && ((state == ST_IDLE) || (state == ST_DONE) || (state == ST_ERROR));
   assign word_inc  = word_cnt + CNT_W'(1);
   assign len_eff   = (CNT_W'(len) > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : CNT_W'(len);

   word_packer u_packer (
      .clk       (clk),
      .rst       (rst),
      .clear     (start_ok),
      .shift_en  (byte_fire),
      .byte_in   (byte_data),
      .word      (word),
      .last_byte (last_byte)
   );

   // State register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= ST_IDLE;
      else     state <= state_next;
   end

   // Next-state logic; all outputs decode from state so byte_valid never reaches imem_we.
   always_comb begin
      state_next = state;
      byte_ready = 1'b0;
      imem_we    = 1'b0;
      imem_addr  = addr_hold;
      imem_wdata = wdata_hold;
      busy       = 1'b0;
      done       = 1'b0;
      err        = 1'b0;
      cpu_hold   = 1'b1;
      case (state)
         ST_IDLE: begin
            if (start_ok) state_next = (len_eff == '0) ? ST_DONE : ST_RECV;
         end
         ST_RECV: begin
            byte_ready = 1'b1;
            busy       = 1'b1;
            if (byte_valid && last_byte)                        state_next = ST_WRITE;
            else if (!byte_valid && to_cnt == TO_W'(TIMEOUT - 1)) state_next = ST_ERROR;
         end
         ST_WRITE: begin
            imem_we    = 1'b1;
            busy       = 1'b1;
            imem_addr  = word_cnt[ADDR_W-1:0];
            imem_wdata = WIDTH'(word);
            state_next = (word_inc == eff_len) ? ST_DONE : ST_RECV;
         end
         ST_DONE: begin
            done     = 1'b1;
            cpu_hold = 1'b0;
            if (start_ok) state_next = (len_eff == '0) ? ST_DONE : ST_RECV;
         end
         ST_ERROR: begin
            err = 1'b1;
            if (start_ok) state_next = (len_eff == '0) ? ST_DONE : ST_RECV;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Word count, latched length and inter-byte idle counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         word_cnt <= '0;
         eff_len  <= '0;
         to_cnt   <= '0;
      end else if (start_ok) begin
         word_cnt <= '0;
         eff_len  <= len_eff;
         to_cnt   <= '0;
      end else begin
         if (state == ST_WRITE) word_cnt <= word_inc;
         if (state == ST_RECV)  to_cnt   <= byte_fire ? '0 : to_cnt + TO_W'(1);
      end
   end

   // Remember the last write so address and data stay put between strobes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         addr_hold  <= '0;
         wdata_hold <= '0;
      end else if (state == ST_WRITE) begin
         addr_hold  <= word_cnt[ADDR_W-1:0];
         wdata_hold <= WIDTH'(word);
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: table of whole loads plus hand-written corner sequences.
module tb_imem_loader;

   localparam int WIDTH   = 32;
   localparam int DEPTH   = 256;
   localparam int TIMEOUT = 1024;
   localparam int ADDR_W  = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [8:0]        len;
   logic              byte_valid;
   logic [7:0]        byte_data;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [WIDTH-1:0]  imem_wdata;
   logic              cpu_hold;
   logic              busy;
   logic              done;
   logic              err;

   int n_checks = 0;
   int n_fail   = 0;
   int ready_in_write = 0;

   logic [ADDR_W-1:0] wr_addr[$];
   logic [WIDTH-1:0]  wr_data[$];

   typedef struct {
      logic [8:0]  len;
      int          n_words;
      logic [31:0] w0;
      logic [31:0] w1;
      int          exp_writes;
      logic        exp_done;
      logic        exp_err;
      logic        exp_hold;
   } vec_t;

   vec_t vecs[4];

   imem_loader #(.WIDTH(WIDTH), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .len        (len),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .imem_we    (imem_we),
      .imem_addr  (imem_addr),
      .imem_wdata (imem_wdata),
      .cpu_hold   (cpu_hold),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   // Log every write strobe on the falling edge.
   always @(negedge clk) begin
      if (imem_we) begin
         wr_addr.push_back(imem_addr);
         wr_data.push_back(imem_wdata);
         if (byte_ready) ready_in_write++;
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] wordFor(input int i);
      logic [7:0] b;
      b = i[7:0];
      return {b, b ^ 8'h5A, 8'hC3, ~b};
   endfunction

   task automatic clearLog();
      wr_addr.delete();
      wr_data.delete();
      ready_in_write = 0;
   endtask

   task automatic startLoad(input logic [8:0] l);
      len   = l;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic sendByte(input logic [7:0] b);
      int guard;
      guard      = 0;
      byte_valid = 1'b1;
      byte_data  = b;
      while (!byte_ready && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (!byte_ready) begin
         n_checks++;
         n_fail++;
         $display("[TB] FAIL byte_accept: byte_ready stayed %0b, expected 1", byte_ready);
      end
      @(posedge clk); #1;
   endtask

   task automatic sendWord(input logic [31:0] w, input bit rnd);
      logic [31:0] sh;
      sh = w;
      for (int b = 0; b < 4; b++) begin
         if (rnd) begin
            int g;
            g = $urandom_range(0, 3);
            byte_valid = 1'b0;
            repeat (g) begin @(posedge clk); #1; end
         end
         sendByte(sh[31:24]);
         sh = sh << 8;
      end
   endtask

   task automatic waitEnd();
      int k;
      k = 0;
      while (!(done || err) && k < 5000) begin
         @(posedge clk); #1;
         k++;
      end
      checkOutput("load_finished", 32'(done || err), 32'd1);
   endtask

   task automatic checkReset(input string tag);
      checkOutput({tag, "_byte_ready"}, 32'(byte_ready), 32'd0);
      checkOutput({tag, "_imem_we"},    32'(imem_we),    32'd0);
      checkOutput({tag, "_imem_addr"},  32'(imem_addr),  32'd0);
      checkOutput({tag, "_imem_wdata"}, imem_wdata,      32'd0);
      checkOutput({tag, "_busy"},       32'(busy),       32'd0);
      checkOutput({tag, "_done"},       32'(done),       32'd0);
      checkOutput({tag, "_err"},        32'(err),        32'd0);
      checkOutput({tag, "_cpu_hold"},   32'(cpu_hold),   32'd1);
   endtask

   task automatic applyStimulus(input vec_t v);
      clearLog();
      startLoad(v.len);
      checkOutput("err_cleared_on_start", 32'(err), 32'd0);
      if (v.len == 9'd0) checkOutput("len0_done_next_cycle", 32'(done), 32'd1);
      if (v.n_words > 0) sendWord(v.w0, 1'b0);
      if (v.n_words > 1) sendWord(v.w1, 1'b0);
      byte_valid = 1'b0;
      waitEnd();
      checkOutput("vec_write_count", 32'(wr_addr.size()), 32'(v.exp_writes));
      for (int i = 0; i < v.exp_writes && i < wr_addr.size(); i++) begin
         checkOutput("vec_write_addr", 32'(wr_addr[i]), 32'(i));
         checkOutput("vec_write_data", wr_data[i], (i == 0) ? v.w0 : v.w1);
      end
      checkOutput("vec_done",     32'(done),     32'(v.exp_done));
      checkOutput("vec_err",      32'(err),      32'(v.exp_err));
      checkOutput("vec_cpu_hold", 32'(cpu_hold), 32'(v.exp_hold));
      checkOutput("vec_busy",     32'(busy),     32'd0);
      if (v.exp_writes > 0) begin
         checkOutput("hold_addr", 32'(imem_addr), 32'(v.exp_writes - 1));
         checkOutput("hold_data", imem_wdata, (v.exp_writes == 1) ? v.w0 : v.w1);
      end
   endtask

   initial begin
      vecs[0] = '{len: 9'd2, n_words: 2, w0: 32'h20100078, w1: 32'h00008820,
                  exp_writes: 2, exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};
      vecs[1] = '{len: 9'd0, n_words: 0, w0: 32'h0, w1: 32'h0,
                  exp_writes: 0, exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};
      vecs[2] = '{len: 9'd1, n_words: 1, w0: 32'hDEADBEEF, w1: 32'h0,
                  exp_writes: 1, exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};
      vecs[3] = '{len: 9'd2, n_words: 2, w0: 32'hCAFEF00D, w1: 32'h12345678,
                  exp_writes: 2, exp_done: 1'b1, exp_err: 1'b0, exp_hold: 1'b0};

      rst        = 1'b0;
      start      = 1'b0;
      len        = 9'd0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      #1 rst = 1'b1;
      #1;
      checkReset("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      $display("[TB] table of whole loads");
      foreach (vecs[i]) applyStimulus(vecs[i]);

      $display("[TB] timeout after three bytes");
      clearLog();
      startLoad(9'd1);
      sendByte(8'h11);
      sendByte(8'h22);
      sendByte(8'h33);
      byte_valid = 1'b0;
      repeat (TIMEOUT - 1) @(posedge clk);
      #1;
      checkOutput("timeout_err_one_early", 32'(err),  32'd0);
      checkOutput("timeout_busy_one_early", 32'(busy), 32'd1);
      @(posedge clk); #1;
      checkOutput("timeout_err",        32'(err),             32'd1);
      checkOutput("timeout_cpu_hold",   32'(cpu_hold),        32'd1);
      checkOutput("timeout_byte_ready", 32'(byte_ready),      32'd0);
      checkOutput("timeout_writes",     32'(wr_addr.size()),  32'd0);

      $display("[TB] start ignored while loading");
      clearLog();
      startLoad(9'd2);
      sendWord(32'hA1B2C3D4, 1'b0);
      byte_valid = 1'b0;
      len   = 9'd5;
      start = 1'b1;
      @(posedge clk); #1;
      @(posedge clk); #1;
      start = 1'b0;
      checkOutput("ignore_start_busy", 32'(busy), 32'd1);
      sendWord(32'h0F1E2D3C, 1'b0);
      byte_valid = 1'b0;
      waitEnd();
      checkOutput("ignore_start_writes", 32'(wr_addr.size()), 32'd2);
      if (wr_addr.size() == 2) begin
         checkOutput("ignore_start_addr1", 32'(wr_addr[1]), 32'd1);
         checkOutput("ignore_start_data1", wr_data[1], 32'h0F1E2D3C);
      end
      checkOutput("ignore_start_done", 32'(done), 32'd1);

      $display("[TB] 14 words with ragged byte_valid");
      clearLog();
      startLoad(9'd14);
      for (int i = 0; i < 14; i++) sendWord(wordFor(i + 40), 1'b1);
      byte_valid = 1'b0;
      waitEnd();
      checkOutput("ragged_writes", 32'(wr_addr.size()), 32'd14);
      for (int i = 0; i < 14 && i < wr_addr.size(); i++) begin
         checkOutput("ragged_addr", 32'(wr_addr[i]), 32'(i));
         checkOutput("ragged_data", wr_data[i], wordFor(i + 40));
      end
      checkOutput("ragged_ready_low_in_write", 32'(ready_in_write), 32'd0);
      checkOutput("ragged_done", 32'(done), 32'd1);

      $display("[TB] reset in the middle of a load");
      clearLog();
      startLoad(9'd10);
      for (int i = 0; i < 5; i++) sendWord(wordFor(i), 1'b0);
      sendByte(8'hAA);
      byte_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      checkReset("midreset");
      @(posedge clk); #1;
      rst = 1'b0;
      checkOutput("midreset_writes", 32'(wr_addr.size()), 32'd5);
      clearLog();
      startLoad(9'd3);
      for (int i = 0; i < 3; i++) sendWord(wordFor(i + 100), 1'b0);
      byte_valid = 1'b0;
      waitEnd();
      checkOutput("after_reset_writes", 32'(wr_addr.size()), 32'd3);
      for (int i = 0; i < 3 && i < wr_addr.size(); i++) begin
         checkOutput("after_reset_addr", 32'(wr_addr[i]), 32'(i));
         checkOutput("after_reset_data", wr_data[i], wordFor(i + 100));
      end

      $display("[TB] len beyond depth is clipped");
      clearLog();
      startLoad(9'd300);
      for (int i = 0; i < 256; i++) sendWord(wordFor(i), 1'b0);
      byte_valid = 1'b0;
      waitEnd();
      checkOutput("clip_writes", 32'(wr_addr.size()), 32'd256);
      for (int i = 0; i < 256 && i < wr_addr.size(); i++) begin
         checkOutput("clip_addr", 32'(wr_addr[i]), 32'(i));
         checkOutput("clip_data", wr_data[i], wordFor(i));
      end
      checkOutput("clip_done",     32'(done),     32'd1);
      checkOutput("clip_cpu_hold", 32'(cpu_hold), 32'd0);
      checkOutput("clip_last_addr", 32'(imem_addr), 32'd255);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
